// File: rtl/button_conditioner.sv
// button_conditioner
// Synchronises and debounces active-low push-buttons. Produces clean,
// single-cycle press / release / long-press strobes and captures the
// code-switch bus on every accepted press, so code_q and code_valid
// appear in the same cycle as the press strobe.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50000,
    parameter int CODE_W          = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic [CODE_W-1:0] code_raw,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  press_pulse,
    output logic [N_BTN-1:0]  release_pulse,
    output logic [N_BTN-1:0]  long_pulse,
    output logic [CODE_W-1:0] code_q,
    output logic              code_valid
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1; hold counter
    // has to reach LONG_CYCLES itself, hence the +1.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LIMIT = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HCNT_FIRE  = HW'(LONG_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Buttons idle high (released), code idles 0.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0]  btn_sync1_reg;
    logic [N_BTN-1:0]  btn_sync2_reg;
    logic [CODE_W-1:0] code_sync1_reg;
    logic [CODE_W-1:0] code_sync2_reg;

    // Bring the asynchronous pads into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_sync1_reg  <= '1;
            btn_sync2_reg  <= '1;
            code_sync1_reg <= '0;
            code_sync2_reg <= '0;
        end else begin
            btn_sync1_reg  <= btn_raw;
            btn_sync2_reg  <= btn_sync1_reg;
            code_sync1_reg <= code_raw;
            code_sync2_reg <= code_sync1_reg;
        end
    end

    // Per-channel press decisions, gathered for the shared code capture.
    logic [N_BTN-1:0] press_next_vec;

    // ------------------------------------------------------------------
    // Per-channel debounce, edge strobes and long-press detection.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic          stable_reg;
            logic          stable_next;
            logic [DW-1:0] dcnt_reg;
            logic [DW-1:0] dcnt_next;
            logic          flip;
            logic          press_reg;
            logic          press_next;
            logic          release_reg;
            logic          release_next;
            logic [HW-1:0] hcnt_reg;
            logic [HW-1:0] hcnt_next;
            logic          long_reg;
            logic          long_next;
            logic          level;

            // Raw polarity is active-low; the debounced level is active-high.
            assign level = ~stable_reg;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive
            // mismatching samples; any agreeing sample restarts the count.
            always_comb begin
                stable_next = stable_reg;
                dcnt_next   = dcnt_reg;
                flip        = 1'b0;
                if (btn_sync2_reg[gi] == stable_reg) begin
                    dcnt_next = '0;
                end else if (dcnt_reg == DCNT_LAST) begin
                    stable_next = btn_sync2_reg[gi];
                    dcnt_next   = '0;
                    flip        = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end

            // A flip to 0 (raw) is a press, a flip to 1 is a release; the two
            // are mutually exclusive by construction.
            always_comb begin
                press_next   = flip & ~stable_next;
                release_next = flip &  stable_next;
            end

            // Hold counter runs while the debounced level is high, saturates
            // at LONG_CYCLES and fires the long strobe only on the way up.
            always_comb begin
                hcnt_next = hcnt_reg;
                long_next = 1'b0;
                if (!level) begin
                    hcnt_next = '0;
                end else if (hcnt_reg != HCNT_LIMIT) begin
                    hcnt_next = hcnt_reg + HW'(1);
                    if (hcnt_reg == HCNT_FIRE) begin
                        long_next = 1'b1;
                    end
                end
            end

            // Channel state and registered strobes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stable_reg  <= 1'b1;
                    dcnt_reg    <= '0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    hcnt_reg    <= '0;
                    long_reg    <= 1'b0;
                end else begin
                    stable_reg  <= stable_next;
                    dcnt_reg    <= dcnt_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                    hcnt_reg    <= hcnt_next;
                    long_reg    <= long_next;
                end
            end

            assign press_next_vec[gi] = press_next;
            assign btn_level[gi]      = level;
            assign press_pulse[gi]    = press_reg;
            assign release_pulse[gi]  = release_reg;
            assign long_pulse[gi]     = long_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Code capture: one capture and one valid strobe per press event, even
    // when several channels are accepted on the same edge.
    // ------------------------------------------------------------------
    logic              any_press;
    logic [CODE_W-1:0] code_q_reg;
    logic              code_valid_reg;

    assign any_press = |press_next_vec;

    // Latch the synchronised code alongside the press strobe load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q_reg     <= '0;
            code_valid_reg <= 1'b0;
        end else begin
            code_valid_reg <= any_press;
            if (any_press) begin
                code_q_reg <= code_sync2_reg;
            end
        end
    end

    assign code_q     = code_q_reg;
    assign code_valid = code_valid_reg;

endmodule
